// File: rtl/stream_csr_pkg.sv
// Shared CSR map and sequencer state encoding for the DDR3 copy stream.
// read_master and write_master decode the same register addresses.
package stream_csr_pkg;

  localparam logic [2:0] CSR_ADDR     = 3'd0;
  localparam logic [2:0] CSR_NSAMPLES = 3'd1;
  localparam logic [2:0] CSR_STEP     = 3'd2;
  localparam logic [2:0] CSR_RATE     = 3'd3;
  localparam logic [2:0] CSR_START    = 3'd4;
  localparam logic [2:0] CSR_DONE     = 3'd5;
  localparam logic [2:0] CSR_RESET    = 3'd6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_CFG,
    ST_WR_CFG,
    ST_START_WR,
    ST_START_RD,
    ST_POLL,
    ST_POLL_WAIT,
    ST_GAP,
    ST_HOLD,
    ST_RST_RD,
    ST_RST_WR,
    ST_FIN
  } state_t;

  // States where abort jumps straight to the reset writes. Once the reset
  // writes have begun the sequence is already winding down.
  function automatic logic is_abortable(state_t s);
    return !(s inside {ST_IDLE, ST_RST_RD, ST_RST_WR, ST_FIN});
  endfunction

endpackage

// File: rtl/stream_csr_sequencer_if.sv
// Avalon-MM CSR link without waitrequest; read data is valid one cycle
// after the read strobe.
interface stream_csr_sequencer_if;
  logic [2:0]  addr;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic [31:0] readdata;

  modport master (output addr, output writedata, output write, output read,
                  input readdata);
  modport slave  (input addr, input writedata, input write, input read,
                  output readdata);
endinterface

// File: rtl/stream_csr_sequencer.sv
// CSR initiator that programs, starts, polls and resets the read and write
// masters for one DDR3 copy stream per accepted start pulse.
module stream_csr_sequencer
  import stream_csr_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 50,
  parameter int unsigned POLL_GAP     = 4,
  parameter logic [15:0] POLL_TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_src_addr,
  input  logic [31:0] cfg_dst_addr,
  input  logic [31:0] cfg_nsamples,
  input  logic [31:0] cfg_step,
  input  logic [31:0] cfg_rate,
  output logic        busy,
  output logic        done,
  output logic        error,
  stream_csr_sequencer_if.master rd_csr,
  stream_csr_sequencer_if.master wr_csr
);

  state_t      state_reg, state_next;
  // One counter serves as config word index, poll gap timer and hold timer.
  logic [31:0] cnt_reg, cnt_next, cnt_inc;
  logic [15:0] poll_cnt_reg, poll_cnt_next;
  logic [16:0] poll_inc;
  logic        error_reg, error_next;

  logic [31:0] src_reg, dst_reg, nsamples_reg, step_reg, rate_reg;

  logic [2:0]  rd_addr, wr_addr;
  logic [31:0] rd_wdata, wr_wdata;
  logic        rd_write, rd_read, wr_write, wr_read;

  // State, counters and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      poll_cnt_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      poll_cnt_reg <= poll_cnt_next;
      error_reg    <= error_next;
    end
  end

  // Capture the configuration on the accepted start; inputs may move later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_reg      <= '0;
      dst_reg      <= '0;
      nsamples_reg <= '0;
      step_reg     <= '0;
      rate_reg     <= '0;
    end else if (state_reg == ST_IDLE && start) begin
      src_reg      <= cfg_src_addr;
      dst_reg      <= cfg_dst_addr;
      nsamples_reg <= cfg_nsamples;
      step_reg     <= cfg_step;
      rate_reg     <= cfg_rate;
    end
  end

  // Next state, counters and the single-cycle CSR strobes for each state.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    poll_cnt_next = poll_cnt_reg;
    error_next    = error_reg;
    cnt_inc       = cnt_reg + 32'd1;
    poll_inc      = {1'b0, poll_cnt_reg} + 17'd1;
    rd_addr       = '0;
    rd_wdata      = '0;
    rd_write      = 1'b0;
    rd_read       = 1'b0;
    wr_addr       = '0;
    wr_wdata      = '0;
    wr_write      = 1'b0;
    wr_read       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_RD_CFG;
          cnt_next      = '0;
          poll_cnt_next = '0;
          error_next    = 1'b0;
        end
      end
      ST_RD_CFG: begin
        rd_write = 1'b1;
        rd_addr  = CSR_ADDR + cnt_reg[2:0];
        case (cnt_reg[1:0])
          2'd0:    rd_wdata = src_reg;
          2'd1:    rd_wdata = nsamples_reg;
          2'd2:    rd_wdata = step_reg;
          default: rd_wdata = rate_reg;
        endcase
        if (cnt_reg == 32'd3) begin
          state_next = ST_WR_CFG;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_WR_CFG: begin
        wr_write = 1'b1;
        wr_addr  = CSR_ADDR + cnt_reg[2:0];
        case (cnt_reg[1:0])
          2'd0:    wr_wdata = dst_reg;
          2'd1:    wr_wdata = nsamples_reg;
          default: wr_wdata = step_reg;
        endcase
        if (cnt_reg == 32'd2) begin
          state_next = ST_START_WR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_START_WR: begin
        // Write master goes first so it is ready before data arrives.
        wr_write   = 1'b1;
        wr_addr    = CSR_START;
        wr_wdata   = 32'd1;
        state_next = ST_START_RD;
      end
      ST_START_RD: begin
        rd_write   = 1'b1;
        rd_addr    = CSR_START;
        rd_wdata   = 32'd1;
        state_next = ST_POLL;
      end
      ST_POLL: begin
        rd_read    = 1'b1;
        rd_addr    = CSR_DONE;
        state_next = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        cnt_next = '0;
        if (rd_csr.readdata != 32'd0) begin
          state_next = (HOLD_CYCLES == 0) ? ST_RST_RD : ST_HOLD;
        end else if (poll_inc >= {1'b0, POLL_TIMEOUT}) begin
          poll_cnt_next = POLL_TIMEOUT;
          error_next    = 1'b1;
          state_next    = ST_RST_RD;
        end else begin
          poll_cnt_next = poll_inc[15:0];
          state_next    = (POLL_GAP == 0) ? ST_POLL : ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_inc >= POLL_GAP) begin
          state_next = ST_POLL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (cnt_inc >= HOLD_CYCLES) begin
          state_next = ST_RST_RD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_RST_RD: begin
        rd_write   = 1'b1;
        rd_addr    = CSR_RESET;
        rd_wdata   = 32'd1;
        state_next = ST_RST_WR;
      end
      ST_RST_WR: begin
        wr_write   = 1'b1;
        wr_addr    = CSR_RESET;
        wr_wdata   = 32'd1;
        state_next = ST_FIN;
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Any strobe already driven this cycle still completes; the reset
    // writes follow on the next cycle.
    if (abort && is_abortable(state_reg)) begin
      state_next = ST_RST_RD;
      cnt_next   = '0;
      error_next = 1'b1;
    end
  end

  assign rd_csr.addr      = rd_addr;
  assign rd_csr.writedata = rd_wdata;
  assign rd_csr.write     = rd_write;
  assign rd_csr.read      = rd_read;
  assign wr_csr.addr      = wr_addr;
  assign wr_csr.writedata = wr_wdata;
  assign wr_csr.write     = wr_write;
  assign wr_csr.read      = wr_read;

  assign busy  = (state_reg != ST_IDLE) && (state_reg != ST_FIN);
  assign done  = (state_reg == ST_FIN);
  assign error = error_reg;

endmodule

// File: tb/tb_stream_csr_sequencer.sv
// Bench for stream_csr_sequencer: table of runs plus random runs, each
// checked against a transaction schedule derived from the sequence timing.
module tb_stream_csr_sequencer;

  localparam int unsigned G  = 4;
  localparam int unsigned H  = 50;
  localparam logic [15:0] TO = 16'd5;
  localparam int MAXC = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] cfg_src_addr = '0, cfg_dst_addr = '0, cfg_nsamples = '0;
  logic [31:0] cfg_step = '0, cfg_rate = '0;
  logic        busy, done, error;

  stream_csr_sequencer_if rd_if();
  stream_csr_sequencer_if wr_if();

  stream_csr_sequencer #(.HOLD_CYCLES(H), .POLL_GAP(G), .POLL_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
    .cfg_nsamples(cfg_nsamples), .cfg_step(cfg_step), .cfg_rate(cfg_rate),
    .busy(busy), .done(done), .error(error),
    .rd_csr(rd_if), .wr_csr(wr_if)
  );

  typedef struct {
    int t; bit port; bit wr; logic [2:0] addr; logic [31:0] data;
  } txn_t;

  // k: poll number that returns done (0 = never); ab0..ab1: abort window
  // (ab1 < 0 = none); bs: cycle of an extra start while busy (-1 = none);
  // exp_done / exp_err: hand-derived results (exp_done < 0 = not tabled).
  typedef struct {
    int k; int ab0; int ab1; int bs; int exp_done; bit exp_err;
  } vec_t;

  txn_t exp_q[$];
  txn_t got_q[$];
  int n_vec = 0, n_fail = 0;
  logic [31:0] l_src, l_dst, l_ns, l_step, l_rate;

  task automatic check_int(input string nm, input int id, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0d, required %0d", nm, id, act, req);
    end
  endtask

  task automatic push_exp(input int t, input bit port, input bit wr,
                          input logic [2:0] a, input logic [31:0] d);
    txn_t x;
    x.t = t; x.port = port; x.wr = wr; x.addr = a; x.data = wr ? d : 32'd0;
    exp_q.push_back(x);
  endtask

  // Expected CSR traffic, relative to the start cycle 0.
  task automatic model(input vec_t v, output int edone, output bit eerr);
    bit timed_out;
    int n, last, r, lo;
    exp_q.delete();
    push_exp(1, 0, 1, 3'd0, l_src);
    push_exp(2, 0, 1, 3'd1, l_ns);
    push_exp(3, 0, 1, 3'd2, l_step);
    push_exp(4, 0, 1, 3'd3, l_rate);
    push_exp(5, 1, 1, 3'd0, l_dst);
    push_exp(6, 1, 1, 3'd1, l_ns);
    push_exp(7, 1, 1, 3'd2, l_step);
    push_exp(8, 1, 1, 3'd4, 32'd1);
    push_exp(9, 0, 1, 3'd4, 32'd1);
    timed_out = (v.k == 0) || (v.k > int'(TO));
    n = timed_out ? int'(TO) : v.k;
    for (int i = 1; i <= n; i++) push_exp(10 + (i - 1) * (int'(G) + 2), 0, 0, 3'd5, 32'd0);
    last = 10 + (n - 1) * (int'(G) + 2);
    r = timed_out ? last + 2 : last + 2 + int'(H);
    eerr = timed_out;
    if (v.ab1 >= 0) begin
      lo = (v.ab0 < 1) ? 1 : v.ab0;
      if (lo <= v.ab1 && lo <= r - 1) begin
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].t > lo) void'(exp_q.pop_back());
        r = lo + 1;
        eerr = 1'b1;
      end
    end
    push_exp(r, 0, 1, 3'd6, 32'd1);
    push_exp(r + 1, 1, 1, 3'd6, 32'd1);
    edone = r + 2;
  endtask

  task automatic capture(input int c, inout int both_bad);
    txn_t x;
    if ((rd_if.write || rd_if.read) && (wr_if.write || wr_if.read)) both_bad++;
    x.t = c;
    if (rd_if.write) begin x.port = 0; x.wr = 1; x.addr = rd_if.addr; x.data = rd_if.writedata; got_q.push_back(x); end
    if (rd_if.read)  begin x.port = 0; x.wr = 0; x.addr = rd_if.addr; x.data = 0; got_q.push_back(x); end
    if (wr_if.write) begin x.port = 1; x.wr = 1; x.addr = wr_if.addr; x.data = wr_if.writedata; got_q.push_back(x); end
    if (wr_if.read)  begin x.port = 1; x.wr = 0; x.addr = wr_if.addr; x.data = 0; got_q.push_back(x); end
  endtask

  // Runs one sequence. Entered and left 1 time unit after a rising edge.
  // stop_at >= 0 returns early at that cycle, leaving the run in flight.
  task automatic run_vec(input int id, input vec_t v, input int stop_at);
    int edone, done_c, both_bad, prof_bad, err1, err_done, poll_idx, mis, bs;
    bit eerr;
    logic [31:0] pending;
    l_src = $urandom; l_dst = $urandom; l_ns = $urandom; l_step = $urandom; l_rate = $urandom;
    cfg_src_addr = l_src; cfg_dst_addr = l_dst; cfg_nsamples = l_ns;
    cfg_step = l_step; cfg_rate = l_rate;
    model(v, edone, eerr);
    bs = (v.bs >= edone) ? -1 : v.bs;
    got_q.delete();
    done_c = -1; both_bad = 0; prof_bad = 0; err1 = -1; err_done = -1;
    poll_idx = 0; pending = 32'd0;
    for (int c = 0; c < MAXC; c++) begin
      rd_if.readdata = pending;
      pending = 32'd0;
      start = (c == 0) || (c == bs);
      abort = (v.ab1 >= 0) && (c >= v.ab0) && (c <= v.ab1);
      if (c > 0) begin
        cfg_src_addr = $urandom; cfg_dst_addr = $urandom; cfg_nsamples = $urandom;
        cfg_step = $urandom; cfg_rate = $urandom;
      end
      capture(c, both_bad);
      if (rd_if.read && rd_if.addr == 3'd5) begin
        poll_idx++;
        if (poll_idx == v.k) pending = 32'd1 << $urandom_range(31, 0);
      end
      if (busy !== ((c >= 1) && (c < edone))) prof_bad++;
      if (done !== (c == edone)) prof_bad++;
      if (c == 1) err1 = int'(error);
      if (c == stop_at) return;
      if (done === 1'b1) begin
        done_c = c;
        err_done = int'(error);
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    mis = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (mis < 0 && !(exp_q[i].t == got_q[i].t && exp_q[i].port == got_q[i].port &&
          exp_q[i].wr == got_q[i].wr && exp_q[i].addr == got_q[i].addr &&
          exp_q[i].data == got_q[i].data)) mis = i;
    end
    n_vec++;
    if (mis >= 0) begin
      n_fail++;
      $display("FAIL txn_order (vec %0d) idx %0d: got t=%0d port=%0d wr=%0d addr=%0d data=%h, required t=%0d port=%0d wr=%0d addr=%0d data=%h",
               id, mis, got_q[mis].t, got_q[mis].port, got_q[mis].wr, got_q[mis].addr, got_q[mis].data,
               exp_q[mis].t, exp_q[mis].port, exp_q[mis].wr, exp_q[mis].addr, exp_q[mis].data);
    end
    check_int("txn_count", id, got_q.size(), exp_q.size());
    check_int("done_cycle", id, done_c, edone);
    if (v.exp_done >= 0) check_int("done_table", id, done_c, v.exp_done);
    if (v.exp_done >= 0) check_int("error_table", id, err_done, int'(v.exp_err));
    check_int("error_at_done", id, err_done, int'(eerr));
    check_int("error_cleared", id, err1, 0);
    check_int("busy_done_profile", id, prof_bad, 0);
    check_int("single_port_strobe", id, both_bad, 0);
    $display("vec %0d: k=%0d abort=[%0d,%0d] txns=%0d done@%0d err=%0d",
             id, v.k, v.ab0, v.ab1, got_q.size(), done_c, err_done);
    if (done_c < 0) begin
      rst = 1'b0; @(posedge clk); #1; rst = 1'b1; @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl[15];
  vec_t rv;
  int idle_bad;
  logic err_before;

  initial begin
    // k, ab0, ab1, bs, exp_done, exp_err  (POLL_GAP=4, HOLD=50, TIMEOUT=5)
    tbl[0]  = '{3, -1, -1, -1, 76, 1'b0};   // done on third poll
    tbl[1]  = '{1, -1, -1, -1, 64, 1'b0};
    tbl[2]  = '{0, -1, -1, -1, 38, 1'b1};   // timeout after 5 polls
    tbl[3]  = '{5, -1, -1, -1, 88, 1'b0};   // done on the last allowed poll
    tbl[4]  = '{6, -1, -1, -1, 38, 1'b1};
    tbl[5]  = '{3, 6, 6, -1, 9, 1'b1};      // abort in WR_CFG
    tbl[6]  = '{3, 0, 1, -1, 4, 1'b1};      // start+abort in IDLE, abort held
    tbl[7]  = '{3, 0, 0, -1, 76, 1'b0};     // abort only with start: no effect
    tbl[8]  = '{1, 40, 40, -1, 43, 1'b1};   // abort in HOLD
    tbl[9]  = '{3, 75, 75, -1, 76, 1'b0};   // abort in RST_WR ignored
    tbl[10] = '{3, 73, 73, -1, 76, 1'b1};   // abort in last HOLD cycle
    tbl[11] = '{2, -1, -1, 20, 70, 1'b0};   // start while busy ignored
    tbl[12] = '{1, 11, 11, -1, 14, 1'b1};   // abort beats done in POLL_WAIT
    tbl[13] = '{3, 9, 9, -1, 12, 1'b1};     // abort in START_RD
    tbl[14] = '{0, 34, 34, -1, 37, 1'b1};   // abort on final poll

    rd_if.readdata = 32'd0;
    wr_if.readdata = $urandom;
    #2;
    check_int("reset_outputs", -1,
              int'({busy, done, error, rd_if.write, rd_if.read, wr_if.write, wr_if.read}), 0);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(i, tbl[i], -1);

    for (int i = 0; i < 8; i++) begin
      rv.k = $urandom_range(6, 0);
      if ($urandom_range(1, 0) == 1) begin
        rv.ab0 = $urandom_range(90, 0);
        rv.ab1 = rv.ab0 + $urandom_range(2, 0);
      end else begin
        rv.ab0 = -1; rv.ab1 = -1;
      end
      rv.bs = ($urandom_range(1, 0) == 1) ? $urandom_range(60, 2) : -1;
      rv.exp_done = -1; rv.exp_err = 1'b0;
      run_vec(100 + i, rv, -1);
    end

    // Reset asserted mid-poll: outputs drop at once, next start runs fully.
    run_vec(200, tbl[2], 12);
    #2 rst = 1'b0;
    #1;
    check_int("rst_midpoll_outputs", 200,
              int'({busy, done, error, rd_if.write, rd_if.read, wr_if.write, wr_if.read}), 0);
    start = 1'b0; abort = 1'b0;
    @(posedge clk); @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    run_vec(201, tbl[0], -1);

    // Abort held in IDLE has no effect.
    run_vec(202, tbl[2], -1);
    err_before = error;
    idle_bad = 0;
    abort = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (busy || done || rd_if.write || rd_if.read || wr_if.write || wr_if.read) idle_bad++;
      if (error !== err_before) idle_bad++;
    end
    abort = 1'b0;
    check_int("idle_abort_ignored", 202, idle_bad, 0);
    check_int("idle_abort_error_kept", 202, int'(error), 1);
    @(posedge clk); #1;
    run_vec(203, tbl[1], -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
